// File: rtl/adventure_move_sequencer.sv
// adventure_move_sequencer
// Turns raw direction button levels into spaced, single-cycle move pulses for
// the adventure game FSMs. Presses are edge-detected, queued in a small FIFO
// and issued one at a time. The block locks up once the game reports win/die.
//
// Pulse handshake: there is no backpressure. A move is "valid" for exactly one
// cycle (state ISSUE) on one of n/s/e/w, and the game is always "ready": it
// samples the pulse on the edge that leaves ISSUE, which is also the edge that
// pops the FIFO and bumps the move counter.
module adventure_move_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_n,
  input  logic             btn_s,
  input  logic             btn_e,
  input  logic             btn_w,
  input  logic             win,
  input  logic             die,
  output logic             n,
  output logic             s,
  output logic             e,
  output logic             w,
  output logic             busy,
  output logic [CNT_W-1:0] moves,
  output logic             overflow,
  output logic             conflict,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     btn, prev, rise;
  logic           single, multi;
  logic [1:0]     code;
  logic [1:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [GW-1:0]  gap_cnt;
  logic           game_over, active, pop, push, full, drop;
  logic [1:0]     head;

  // Button bit order {w, e, s, n} so that bit index equals the move code.
  assign btn       = {btn_w, btn_e, btn_s, btn_n};
  assign rise      = btn & ~prev;
  assign multi     = (rise & (rise - 4'd1)) != 4'd0;
  assign game_over = win | die;
  assign active    = (state != DONE);
  assign pop       = (state == ISSUE);
  assign full      = (count == (AW+1)'(DEPTH));
  assign push      = active && single && (!full || pop);
  assign drop      = active && single && full && !pop;
  assign head      = mem[rd_ptr];

  // Encode a lone rising edge into its move code.
  always_comb begin
    single = 1'b1;
    code   = 2'd0;
    case (rise)
      4'b0001: code = 2'd0;
      4'b0010: code = 2'd1;
      4'b0100: code = 2'd2;
      4'b1000: code = 2'd3;
      default: single = 1'b0;
    endcase
  end

  // Next-state logic; a game-over report overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (game_over) begin
      state_nxt = DONE;
    end else begin
      case (state)
        IDLE:    if (count != '0) state_nxt = ISSUE;
        ISSUE:   state_nxt = WAIT;
        WAIT:    if (gap_cnt == '0) state_nxt = IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register, edge-detect history and gap timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      prev    <= 4'b1111;
      gap_cnt <= '0;
    end else begin
      state <= state_nxt;
      prev  <= btn;
      if (state == ISSUE) gap_cnt <= GW'(GAP - 1);
      else if (state == WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // FIFO pointers and occupancy; flushed on entry to and while in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (game_over || !active) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code;
  end

  // Saturating move counter and sticky error flags; all hold in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moves    <= '0;
      overflow <= 1'b0;
      conflict <= 1'b0;
    end else begin
      if (pop && moves != '1) moves <= moves + 1'b1;
      if (drop) overflow <= 1'b1;
      if (active && multi) conflict <= 1'b1;
    end
  end

  // Pulse decode and status outputs.
  always_comb begin
    n    = pop && (head == 2'd0);
    s    = pop && (head == 2'd1);
    e    = pop && (head == 2'd2);
    w    = pop && (head == 2'd3);
    done = (state == DONE);
    busy = active && ((count != '0) || (state == ISSUE) || (state == WAIT));
  end

endmodule

// File: tb/tb_adventure_move_sequencer.sv
// Bench for adventure_move_sequencer: two instances share clock, reset and
// win/die. dut_a uses default parameters; dut_b is DEPTH=2, GAP=8, CNT_W=2.
// Expected pulses {cycle, code} are queued by the driver and popped by a
// per-instance monitor whenever a pulse appears.
module tb_adventure_move_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic win, die;
  logic a_bn, a_bs, a_be, a_bw;
  logic b_bn, b_bs, b_be, b_bw;
  logic a_n, a_s, a_e, a_w, a_busy, a_overflow, a_conflict, a_done;
  logic b_n, b_s, b_e, b_w, b_busy, b_overflow, b_conflict, b_done;
  logic [7:0] a_moves;
  logic [1:0] b_moves;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base;

  logic [17:0] exp_a[$];
  logic [17:0] exp_b[$];

  adventure_move_sequencer dut_a (
    .clk(clk), .reset_n(reset_n),
    .btn_n(a_bn), .btn_s(a_bs), .btn_e(a_be), .btn_w(a_bw),
    .win(win), .die(die),
    .n(a_n), .s(a_s), .e(a_e), .w(a_w),
    .busy(a_busy), .moves(a_moves), .overflow(a_overflow),
    .conflict(a_conflict), .done(a_done)
  );

  adventure_move_sequencer #(.DEPTH(2), .GAP(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .btn_n(b_bn), .btn_s(b_bs), .btn_e(b_be), .btn_w(b_bw),
    .win(win), .die(die),
    .n(b_n), .s(b_s), .e(b_e), .w(b_w),
    .busy(b_busy), .moves(b_moves), .overflow(b_overflow),
    .conflict(b_conflict), .done(b_done)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] mk(input int c, input logic [1:0] code);
    logic [31:0] t;
    t = c;
    return {t[15:0], code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_a(input logic [3:0] v);
    {a_bw, a_be, a_bs, a_bn} = v;
  endtask

  task automatic set_b(input logic [3:0] v);
    {b_bw, b_be, b_bs, b_bn} = v;
  endtask

  task automatic press_a(input logic [1:0] code);
    logic [3:0] v;
    v = 4'b0001 << code;
    set_a(v);
    tick();
    set_a(4'b0000);
  endtask

  task automatic press_b(input logic [1:0] code);
    logic [3:0] v;
    v = 4'b0001 << code;
    set_b(v);
    tick();
    set_b(4'b0000);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a_pulses"}, {a_n, a_s, a_e, a_w}, 0);
    check({tag, "_a_flags"}, {a_busy, a_overflow, a_conflict, a_done}, 0);
    check({tag, "_a_moves"}, a_moves, 0);
    check({tag, "_b_pulses"}, {b_n, b_s, b_e, b_w}, 0);
    check({tag, "_b_flags"}, {b_busy, b_overflow, b_conflict, b_done}, 0);
    check({tag, "_b_moves"}, b_moves, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_a(4'b0000);
    set_b(4'b0000);
    win = 1'b0;
    die = 1'b0;
    tick();
    check_zero_outputs("reset");
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor for dut_a pulses.
  logic [3:0]  ma_p;
  logic [1:0]  ma_c;
  logic [17:0] ma_e;
  always @(negedge clk) begin
    ma_p = {a_w, a_e, a_s, a_n};
    if (ma_p != 4'b0000) begin
      ma_c = ma_p[1] ? 2'd1 : ma_p[2] ? 2'd2 : ma_p[3] ? 2'd3 : 2'd0;
      check("a_pulse_onehot", $countones(ma_p), 1);
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_pulse actual=code%0d@cyc%0d expected=none", ma_c, cyc);
      end else begin
        ma_e = exp_a.pop_front();
        if (mk(cyc, ma_c) !== ma_e) begin
          failures++;
          $display("FAIL a_pulse actual=code%0d@cyc%0d expected=code%0d@cyc%0d",
                   ma_c, cyc, ma_e[1:0], ma_e[17:2]);
        end
      end
    end
  end

  // Monitor for dut_b pulses.
  logic [3:0]  mb_p;
  logic [1:0]  mb_c;
  logic [17:0] mb_e;
  always @(negedge clk) begin
    mb_p = {b_w, b_e, b_s, b_n};
    if (mb_p != 4'b0000) begin
      mb_c = mb_p[1] ? 2'd1 : mb_p[2] ? 2'd2 : mb_p[3] ? 2'd3 : 2'd0;
      check("b_pulse_onehot", $countones(mb_p), 1);
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_pulse actual=code%0d@cyc%0d expected=none", mb_c, cyc);
      end else begin
        mb_e = exp_b.pop_front();
        if (mk(cyc, mb_c) !== mb_e) begin
          failures++;
          $display("FAIL b_pulse actual=code%0d@cyc%0d expected=code%0d@cyc%0d",
                   mb_c, cyc, mb_e[1:0], mb_e[17:2]);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    set_a(4'b0000);
    set_b(4'b0000);
    win = 1'b0;
    die = 1'b0;

    // 1) single east press
    do_reset();
    base = cyc;
    exp_a.push_back(mk(base + 2, 2'd2));
    press_a(2'd2);
    check("t1_busy_after_push", a_busy, 1);
    repeat (5) tick();
    check("t1_moves", a_moves, 1);
    check("t1_busy_idle", a_busy, 0);

    // 2) E,S,W,E two cycles apart
    do_reset();
    base = cyc;
    exp_a.push_back(mk(base + 2, 2'd2));
    exp_a.push_back(mk(base + 6, 2'd1));
    exp_a.push_back(mk(base + 10, 2'd3));
    exp_a.push_back(mk(base + 14, 2'd2));
    press_a(2'd2); tick();
    press_a(2'd1); tick();
    press_a(2'd3); tick();
    press_a(2'd2);
    while (cyc < base + 20) tick();
    check("t2_moves", a_moves, 4);
    check("t2_overflow", a_overflow, 0);
    check("t2_busy", a_busy, 0);
    check("t2_queue_drained", exp_a.size(), 0);

    // 3) shallow FIFO overflow, then counter saturation (CNT_W=2)
    do_reset();
    base = cyc;
    exp_b.push_back(mk(base + 2, 2'd2));
    exp_b.push_back(mk(base + 12, 2'd1));
    exp_b.push_back(mk(base + 22, 2'd3));
    press_b(2'd2); tick();
    press_b(2'd1); tick();
    press_b(2'd3); tick();
    press_b(2'd0);
    check("t3_overflow", b_overflow, 1);
    while (cyc < base + 34) tick();
    check("t3_moves", b_moves, 3);
    check("t3_busy", b_busy, 0);
    check("t3_queue_drained", exp_b.size(), 0);
    exp_b.push_back(mk(cyc + 2, 2'd2));
    press_b(2'd2);
    repeat (15) tick();
    check("t3_moves_saturated", b_moves, 3);
    check("t3_a_untouched", a_moves, 0);

    // 4) simultaneous north+east rise
    do_reset();
    set_a(4'b0101);
    tick();
    set_a(4'b0000);
    repeat (6) tick();
    check("t4_conflict", a_conflict, 1);
    check("t4_moves", a_moves, 0);
    check("t4_busy", a_busy, 0);
    check("t4_overflow", a_overflow, 0);

    // 5) die during first WAIT with moves queued
    do_reset();
    base = cyc;
    exp_a.push_back(mk(base + 2, 2'd2));
    press_a(2'd2); tick();
    press_a(2'd1);
    die = 1'b1;
    tick();
    check("t5_done", a_done, 1);
    check("t5_busy", a_busy, 0);
    check("t5_moves", a_moves, 1);
    die = 1'b0;
    press_a(2'd3); tick();
    press_a(2'd0);
    repeat (20) tick();
    check("t5_done_held", a_done, 1);
    check("t5_moves_held", a_moves, 1);
    check("t5_busy_held", a_busy, 0);

    // 6) reset mid-WAIT with two queued and south held
    do_reset();
    base = cyc;
    exp_a.push_back(mk(base + 2, 2'd2));
    set_a(4'b0100); tick();
    set_a(4'b0001); tick();
    set_a(4'b0010); tick();
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("t6_async");
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("t6_busy_held_btn", a_busy, 0);
    check("t6_moves_held_btn", a_moves, 0);
    set_a(4'b0000);
    tick();
    exp_a.push_back(mk(cyc + 2, 2'd1));
    press_a(2'd1);
    repeat (8) tick();
    check("t6_moves_after_repress", a_moves, 1);

    check("final_a_queue_empty", exp_a.size(), 0);
    check("final_b_queue_empty", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
